// File: rtl/dma_burst_ctrl.sv
// dma_burst_ctrl: cycle-stealing DMA that moves a block of words from an
// external device into memory in fixed-size bursts.
//
// Ports:
//   CLK, reset_n           clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready    command handshake; a command is taken only in IDLE
//   cmd_addr, cmd_len      memory start address and word count
//   BR / BG                bus request out / bus grant in
//   READ, WRITE            device read / memory write strobes (granted bursts only)
//   addr, offset, wmask    burst base address, device burst index, word-valid mask
//   edata -> data          device burst data, passed straight through to memory
//   busy, interrupt        not-idle flag, one-cycle completion pulse
module dma_burst_ctrl #(
  parameter int WORD_SIZE   = 16,
  parameter int BURST_WORDS = 4,
  parameter int MEM_LAT     = 1,
  parameter int OFF_W       = 2,
  parameter int STEAL       = 1
) (
  input  logic                             CLK,
  input  logic                             reset_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [WORD_SIZE-1:0]             cmd_addr,
  input  logic [WORD_SIZE-1:0]             cmd_len,
  input  logic                             BG,
  output logic                             BR,
  output logic                             READ,
  output logic                             WRITE,
  output logic [WORD_SIZE-1:0]             addr,
  output logic [BURST_WORDS*WORD_SIZE-1:0] data,
  output logic [BURST_WORDS-1:0]           wmask,
  output logic [OFF_W-1:0]                 offset,
  input  logic [BURST_WORDS*WORD_SIZE-1:0] edata,
  output logic                             busy,
  output logic                             interrupt
);

  localparam int                   LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0]     LAT_LAST = LAT_W'(MEM_LAT - 1);
  localparam logic [WORD_SIZE-1:0] BW       = WORD_SIZE'(BURST_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_REL, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] cur_addr_q, cur_addr_d;
  logic [WORD_SIZE-1:0] remaining_q, remaining_d;
  logic [OFF_W-1:0]     offset_q, offset_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 br_q, br_d;
  logic                 irq_q, irq_d;
  logic [WORD_SIZE-1:0] step;

  // Words retired by the current burst: a full burst, or whatever is left.
  assign step = (remaining_q >= BW) ? BW : remaining_q;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    offset_d    = offset_q;
    lat_d       = lat_q;
    unique case (state_q)
      S_IDLE: if (cmd_valid) begin
        cur_addr_d  = cmd_addr;
        remaining_d = cmd_len;
        offset_d    = '0;
        state_d     = (cmd_len == '0) ? S_DONE : S_REQ;
      end
      S_REQ: if (BG) begin
        state_d = S_XFER;
        lat_d   = '0;
      end
      S_XFER: begin
        if (!BG) begin
          // Preempted: forget partial latency so the burst reruns in full.
          lat_d = '0;
        end else if (lat_q == LAT_LAST) begin
          cur_addr_d  = cur_addr_q + BW;
          remaining_d = remaining_q - step;
          offset_d    = offset_q + 1'b1;
          lat_d       = '0;
          if (remaining_q == step) state_d = S_DONE;
          else if (STEAL != 0)     state_d = S_REL;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_REL:   state_d = S_REQ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    br_d  = (state_d == S_REQ) || (state_d == S_XFER);
    irq_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      offset_q    <= '0;
      lat_q       <= '0;
      br_q        <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      offset_q    <= offset_d;
      lat_q       <= lat_d;
      br_q        <= br_d;
      irq_q       <= irq_d;
    end
  end

  // Strobes are gated by BG directly so they never outlive the grant,
  // even for the cycle in which the arbiter takes the bus back.
  assign WRITE     = (state_q == S_XFER) && BG;
  assign READ      = WRITE;
  assign BR        = br_q;
  assign interrupt = irq_q;
  assign busy      = (state_q != S_IDLE);
  assign cmd_ready = (state_q == S_IDLE);
  assign addr      = cur_addr_q;
  assign offset    = offset_q;
  assign data      = edata;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < BURST_WORDS; i++)
      wmask[i] = (state_q == S_XFER) && (remaining_q > WORD_SIZE'(i));
  end

endmodule
